// File: rtl/snoop_bus_pkg.sv
// snoop_bus_pkg: message/state encodings and fake-memory fill patterns for snoop_bus_ctrl.
// Declarations only; no timing or flow control of its own.
package snoop_bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD   = 2'b00,
    BUS_RDX  = 2'b01,
    BUS_UPGR = 2'b10,
    BUS_NONE = 2'b11
  } bus_msg_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_SNOOP = 3'd2,
    ST_MEM   = 3'd3,
    ST_DONE  = 3'd4
  } bus_state_e;

  localparam logic [15:0] RD_FILL = 16'hCAFE;
  localparam logic [15:0] WR_FILL = 16'hDEAD;

  // Reserved encoding behaves like BusUpgr: no line is returned.
  function automatic logic msg_has_data(input bus_msg_e m);
    return (m == BUS_RD) || (m == BUS_RDX);
  endfunction

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// rr_arbiter: one-hot grant to the first requester at or after ptr, searching upward with wrap.
// Combinational, zero latency; en low forces no grant. The pointer register lives in the parent.
module rr_arbiter
  import snoop_bus_pkg::*;
#(
  parameter int NUM_PROCS = 4,
  localparam int IDX_W = $clog2(NUM_PROCS)
) (
  input  logic [NUM_PROCS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  input  logic                 en,
  output logic [NUM_PROCS-1:0] gnt,
  output logic [IDX_W-1:0]     idx
);

  int   cand;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    cand  = 0;
    found = 1'b0;
    for (int i = 0; i < NUM_PROCS; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NUM_PROCS) cand = cand - NUM_PROCS;
      if (en && !found && req[IDX_W'(cand)]) begin
        found              = 1'b1;
        gnt[IDX_W'(cand)]  = 1'b1;
        idx                = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// snoop_bus_ctrl: round-robin MSI snooping bus; SNOOP_BUS_FLUSH_CHK_EN enables the sticky err_o flush check.
// Grant T+1, done T+3 (flush/upgrade) or T+3+MEM_LATENCY; requesters hold req_i until done_o, no other backpressure.
module snoop_bus_ctrl
  import snoop_bus_pkg::*;
#(
  parameter int NUM_PROCS   = 4,
  parameter int ADDR_SIZE   = 32,
  parameter int LINE_SIZE   = 128,
  parameter int MEM_LATENCY = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NUM_PROCS-1:0]           req_i,
  input  logic [2*NUM_PROCS-1:0]         msg_i,
  input  logic [ADDR_SIZE*NUM_PROCS-1:0] addr_i,
  input  logic [NUM_PROCS-1:0]           flush_i,
  input  logic [LINE_SIZE*NUM_PROCS-1:0] flush_data_i,
  output logic [NUM_PROCS-1:0]           gnt_o,
  output logic                           bus_valid_o,
  output logic [1:0]                     bus_msg_o,
  output logic [ADDR_SIZE-1:0]           bus_addr_o,
  output logic [LINE_SIZE-1:0]           data_o,
  output logic                           data_valid_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int IDX_W = $clog2(NUM_PROCS);
  localparam int CNT_W = $clog2(MEM_LATENCY + 1);

  localparam logic [2:0] IDLE  = ST_IDLE;
  localparam logic [2:0] ADDR  = ST_ADDR;
  localparam logic [2:0] SNOOP = ST_SNOOP;
  localparam logic [2:0] MEM   = ST_MEM;
  localparam logic [2:0] DONE  = ST_DONE;

  localparam logic [LINE_SIZE-1:0] RD_LINE = {LINE_SIZE/16{RD_FILL}};
  localparam logic [LINE_SIZE-1:0] WR_LINE = {LINE_SIZE/16{WR_FILL}};

  logic [2:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [CNT_W-1:0] mem_cnt;
  bus_msg_e         msg_q;

  logic [NUM_PROCS-1:0] arb_gnt;
  logic [IDX_W-1:0]     arb_idx;

  logic [1:0]           msg_arr   [NUM_PROCS];
  logic [ADDR_SIZE-1:0] addr_arr  [NUM_PROCS];
  logic [LINE_SIZE-1:0] fdata_arr [NUM_PROCS];

  for (genvar p = 0; p < NUM_PROCS; p++) begin : g_unpack
    assign msg_arr[p]   = msg_i[2*p +: 2];
    assign addr_arr[p]  = addr_i[ADDR_SIZE*p +: ADDR_SIZE];
    assign fdata_arr[p] = flush_data_i[LINE_SIZE*p +: LINE_SIZE];
  end

  rr_arbiter #(.NUM_PROCS(NUM_PROCS)) u_arb (
    .req (req_i),
    .ptr (rr_ptr),
    .en  (state == IDLE),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign ptr_nxt = (arb_idx == IDX_W'(NUM_PROCS-1)) ? '0 : arb_idx + IDX_W'(1);

  // gnt_o is the registered one-hot owner, so masking with it drops the owner's own flush.
  logic [NUM_PROCS-1:0] flush_peer;
  logic                 flush_any;
  logic [IDX_W-1:0]     fl_idx;

  assign flush_peer = flush_i & ~gnt_o;
  assign flush_any  = |flush_peer;

  always_comb begin
    fl_idx = '0;
    for (int p = NUM_PROCS-1; p >= 0; p--) begin
      if (flush_peer[p]) fl_idx = IDX_W'(p);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      mem_cnt      <= '0;
      msg_q        <= BUS_RD;
      gnt_o        <= '0;
      bus_valid_o  <= 1'b0;
      bus_msg_o    <= '0;
      bus_addr_o   <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      bus_valid_o  <= 1'b0;
      bus_msg_o    <= '0;
      bus_addr_o   <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      done_o       <= 1'b0;
      case (state)
        IDLE: begin
          if (|req_i) begin
            state       <= ADDR;
            gnt_o       <= arb_gnt;
            rr_ptr      <= ptr_nxt;
            msg_q       <= bus_msg_e'(msg_arr[arb_idx]);
            bus_valid_o <= 1'b1;
            bus_msg_o   <= msg_arr[arb_idx];
            bus_addr_o  <= addr_arr[arb_idx];
          end
        end
        ADDR: state <= SNOOP;
        SNOOP: begin
          if (!msg_has_data(msg_q)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end else if (flush_any) begin
            state        <= DONE;
            done_o       <= 1'b1;
            data_valid_o <= 1'b1;
            data_o       <= fdata_arr[fl_idx];
          end else begin
            state   <= MEM;
            mem_cnt <= CNT_W'(MEM_LATENCY - 1);
          end
        end
        MEM: begin
          if (mem_cnt == '0) begin
            state        <= DONE;
            done_o       <= 1'b1;
            data_valid_o <= 1'b1;
            data_o       <= (msg_q == BUS_RD) ? RD_LINE : WR_LINE;
          end else begin
            mem_cnt <= mem_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          gnt_o <= '0;
        end
        default: begin
          state <= IDLE;
          gnt_o <= '0;
        end
      endcase
    end
  end

`ifdef SNOOP_BUS_FLUSH_CHK_EN
  logic flush_multi;
  assign flush_multi = |(flush_peer & (flush_peer - NUM_PROCS'(1)));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_o <= 1'b0;
    end else if (state == SNOOP &&
                 (flush_multi || (flush_any && !msg_has_data(msg_q)))) begin
      err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// tb_snoop_bus_ctrl: directed vector table, reset/round-robin sequences and random transactions
// checked against a transaction-level model of the snooping bus.
module tb_snoop_bus_ctrl;

  localparam int NP = 4;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int ML = 2;
`ifdef SNOOP_BUS_FLUSH_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  localparam logic [LW-1:0] CAFE = {8{16'hCAFE}};
  localparam logic [LW-1:0] DEAD = {8{16'hDEAD}};
  localparam logic [LW-1:0] FD0  = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
  localparam logic [LW-1:0] FD1  = 128'h1111_aaaa_bbbb_cccc_dddd_eeee_ffff_0001;
  localparam logic [LW-1:0] FD2  = 128'h2222_0123_4567_89ab_cdef_fedc_ba98_7654;
  localparam logic [LW-1:0] FD3  = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
  localparam logic [AW-1:0] A0   = 32'h0000_0100;
  localparam logic [AW-1:0] A1   = 32'h0000_0200;
  localparam logic [AW-1:0] A2   = 32'h0000_0040;
  localparam logic [AW-1:0] A3   = 32'h0000_0300;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     req_i;
  logic [2*NP-1:0]   msg_i;
  logic [AW*NP-1:0]  addr_i;
  logic [NP-1:0]     flush_i;
  logic [LW*NP-1:0]  flush_data_i;
  logic [NP-1:0]     gnt_o;
  logic              bus_valid_o;
  logic [1:0]        bus_msg_o;
  logic [AW-1:0]     bus_addr_o;
  logic [LW-1:0]     data_o;
  logic              data_valid_o;
  logic              done_o;
  logic              err_o;

  always #5 clk_i = ~clk_i;

  snoop_bus_ctrl #(.NUM_PROCS(NP), .ADDR_SIZE(AW), .LINE_SIZE(LW), .MEM_LATENCY(ML)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .msg_i        (msg_i),
    .addr_i       (addr_i),
    .flush_i      (flush_i),
    .flush_data_i (flush_data_i),
    .gnt_o        (gnt_o),
    .bus_valid_o  (bus_valid_o),
    .bus_msg_o    (bus_msg_o),
    .bus_addr_o   (bus_addr_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_ptr = 0;
  logic m_err = 1'b0;
  logic [AW-1:0] addr_tab [NP];

  typedef struct {
    logic [NP-1:0]   rq;
    logic [2*NP-1:0] msgs;
    logic [NP-1:0]   fl;
    int              ew;
    logic [1:0]      em;
    logic [AW-1:0]   ea;
    int              el;
    logic            edv;
    logic [LW-1:0]   ed;
    bit              echk;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NP-1:0] rq, input int ptr);
    for (int i = 0; i < NP; i++) begin
      if (rq[(ptr + i) % NP]) return (ptr + i) % NP;
    end
    return 0;
  endfunction

  // Starts in an IDLE cycle with req/msg/addr/flush data already driven; ends in the following IDLE cycle.
  task automatic txn(input string nm, input int ew, input logic [1:0] em, input logic [AW-1:0] ea,
                     input int el, input logic edv, input logic [LW-1:0] ed, input logic [NP-1:0] fl,
                     input bit echk, input bit noise, input bit drop);
    logic early;
    early = 1'b0;
    for (int c = 1; c <= el; c++) begin
      @(posedge clk_i); #1;
      flush_i = (c == 2) ? fl : (noise ? NP'($urandom) : '0);
      if (c == 1) begin
        chk({nm, " gnt"}, LW'(gnt_o), LW'(4'b0001 << ew));
        chk({nm, " bus_valid"}, LW'(bus_valid_o), LW'(1));
        chk({nm, " bus_msg"}, LW'(bus_msg_o), LW'(em));
        chk({nm, " bus_addr"}, LW'(bus_addr_o), LW'(ea));
        if (drop) req_i[ew] = 1'b0;
      end else if (c == 2) begin
        chk({nm, " bus idle"}, LW'({bus_valid_o, bus_msg_o, bus_addr_o}), '0);
      end
      if (c < el && done_o) early = 1'b1;
    end
    chk({nm, " early done"}, LW'(early), '0);
    chk({nm, " done"}, LW'(done_o), LW'(1));
    chk({nm, " data_valid"}, LW'(data_valid_o), LW'(edv));
    chk({nm, " data"}, data_o, ed);
    chk({nm, " gnt held"}, LW'(gnt_o), LW'(4'b0001 << ew));
    m_err = m_err | (echk & CHK_EN);
    chk({nm, " err"}, LW'(err_o), LW'(m_err));
    m_ptr = (ew + 1) % NP;
    @(posedge clk_i); #1;
    flush_i = '0;
    chk({nm, " idle after done"}, LW'({gnt_o, bus_valid_o, done_o, data_valid_o}), '0);
  endtask

  logic [NP-1:0] r_rq, r_fl, r_peer;
  logic [1:0]    r_m;
  logic [LW-1:0] r_d;
  logic          r_dv;
  int            r_w, r_el, r_low;

  initial begin
    addr_tab[0] = A0; addr_tab[1] = A1; addr_tab[2] = A2; addr_tab[3] = A3;
    tbl[0] = '{4'b0100, 8'b01_00_10_01, 4'b0000, 2, 2'b00, A2, 3+ML, 1'b1, CAFE, 1'b0};
    tbl[1] = '{4'b0001, 8'b00_00_00_01, 4'b1000, 0, 2'b01, A0, 3,    1'b1, FD3,  1'b0};
    tbl[2] = '{4'b0010, 8'b00_00_10_00, 4'b0000, 1, 2'b10, A1, 3,    1'b0, '0,   1'b0};
    tbl[3] = '{4'b0001, 8'b00_00_00_00, 4'b0001, 0, 2'b00, A0, 3+ML, 1'b1, CAFE, 1'b0};
    tbl[4] = '{4'b1000, 8'b11_00_00_00, 4'b0000, 3, 2'b11, A3, 3,    1'b0, '0,   1'b0};
    tbl[5] = '{4'b1111, 8'b01_01_01_01, 4'b0000, 0, 2'b01, A0, 3+ML, 1'b1, DEAD, 1'b0};
    tbl[6] = '{4'b1111, 8'b00_00_00_00, 4'b0001, 1, 2'b00, A1, 3,    1'b1, FD0,  1'b0};
    tbl[7] = '{4'b0001, 8'b00_00_00_00, 4'b0110, 0, 2'b00, A0, 3,    1'b1, FD1,  1'b1};
    tbl[8] = '{4'b0010, 8'b00_00_10_00, 4'b0001, 1, 2'b10, A1, 3,    1'b0, '0,   1'b1};
    tbl[9] = '{4'b0010, 8'b00_00_00_00, 4'b0000, 1, 2'b00, A1, 3+ML, 1'b1, CAFE, 1'b0};

    rst_i = 1'b1;
    req_i = '0;
    msg_i = '0;
    flush_i = '0;
    addr_i = {A3, A2, A1, A0};
    flush_data_i = {FD3, FD2, FD1, FD0};
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("reset outputs", LW'({gnt_o, bus_valid_o, bus_msg_o, bus_addr_o, data_valid_o, done_o, err_o}), '0);
    chk("reset data", data_o, '0);

    for (int i = 0; i < 10; i++) begin
      req_i = tbl[i].rq;
      msg_i = tbl[i].msgs;
      txn($sformatf("vec%0d", i), tbl[i].ew, tbl[i].em, tbl[i].ea, tbl[i].el, tbl[i].edv,
          tbl[i].ed, tbl[i].fl, tbl[i].echk, (i % 2) == 1, (i % 3) == 0);
    end

    // Reset while the memory countdown is running.
    req_i = 4'b0100;
    msg_i = '0;
    repeat (3) begin @(posedge clk_i); #1; end
    chk("pre-reset gnt", LW'(gnt_o), LW'(4'b0100));
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("mid reset outputs", LW'({gnt_o, bus_valid_o, bus_msg_o, bus_addr_o, data_valid_o, done_o, err_o}), '0);
    chk("mid reset data", data_o, '0);
    m_ptr = 0;
    m_err = 1'b0;

    // All ports request continuously: grants rotate 0,1,2,3,0.
    req_i = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      txn($sformatf("rr%0d", k), k % NP, 2'b00, addr_tab[k % NP], 3+ML, 1'b1, CAFE, '0, 1'b0, 1'b0, 1'b0);
    end

    for (int k = 0; k < 40; k++) begin
      r_rq = NP'($urandom_range(1, (1 << NP) - 1));
      req_i = r_rq;
      msg_i = 8'($urandom);
      addr_i = {$urandom, $urandom, $urandom, $urandom};
      for (int j = 0; j < (LW * NP) / 32; j++) flush_data_i[32*j +: 32] = $urandom;
      r_fl = NP'($urandom);
      r_w = rr_pick(r_rq, m_ptr);
      r_m = msg_i[2*r_w +: 2];
      r_peer = r_fl & ~(NP'(1) << r_w);
      r_low = 0;
      for (int j = NP - 1; j >= 0; j--) if (r_peer[j]) r_low = j;
      if (r_m[1]) begin
        r_el = 3; r_dv = 1'b0; r_d = '0;
      end else if (r_peer != '0) begin
        r_el = 3; r_dv = 1'b1; r_d = flush_data_i[LW*r_low +: LW];
      end else begin
        r_el = 3 + ML; r_dv = 1'b1; r_d = (r_m == 2'b00) ? CAFE : DEAD;
      end
      txn($sformatf("rand%0d", k), r_w, r_m, addr_i[AW*r_w +: AW], r_el, r_dv, r_d, r_fl,
          ($countones(r_peer) > 1) || (r_m[1] && (r_peer != '0)),
          ($urandom % 2) == 1, ($urandom % 2) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
